// File: rtl/hazard_pkg.sv
// Shared widths and types for the miniRV data-hazard scoreboard.
// Build option: HAZ_PERF_CNT_EN adds the stall-cycle counter.
package hazard_pkg;
    localparam int AW = 5;
    localparam int LAT_W = 3;
    localparam int NREG = 1 << AW;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [LAT_W-1:0] lat_t;
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: fixed-latency countdown plus
// variable-latency pending bit for a single register.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int LAT_W = hazard_pkg::LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_var,
    input  logic [LAT_W-1:0] load_lat,
    input  logic             done,
    output logic             busy,
    output logic             pend
);

    logic [LAT_W-1:0] cnt;

    // A new issue overrides both the countdown and any release
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else if (load) begin
            cnt  <= load_var ? '0 : load_lat;
            pend <= load_var | (pend & ~done);
        end else begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (done)
                pend <= 1'b0;
        end
    end

    assign busy = (cnt != '0) | pend;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside ID: stalls readers and
// WAW writers. HAZ_PERF_CNT_EN adds the stall_cycles counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int AW     = hazard_pkg::AW,
    parameter int LAT_W  = hazard_pkg::LAT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NUM_RD*AW-1:0] id_rs_addr,
    input  logic [NUM_RD-1:0]    id_rs_read,
    input  logic [AW-1:0]        id_rd_addr,
    input  logic                 id_rd_we,
    input  logic [LAT_W-1:0]     id_lat,
    input  logic                 id_var,
    input  logic                 var_done,
    input  logic [AW-1:0]        var_rd,
    input  logic                 flush,
    output logic                 stall,
    output logic [NUM_RD-1:0]    haz_port,
    output logic                 busy_any
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int NR = 1 << AW;

    logic [NR-1:0] busy_v;
    logic [NR-1:0] pend_v;
    logic          waw;
    logic          issue;
    logic          rd_nz;

    // x0 is never tracked
    assign busy_v[0] = 1'b0;
    assign pend_v[0] = 1'b0;

    assign rd_nz = (id_rd_addr != '0);

    for (genvar r = 1; r < NR; r++) begin : g_ent
        logic hit_rd;
        logic hit_done;

        assign hit_rd   = issue & (id_rd_addr == AW'(r));
        assign hit_done = var_done & (var_rd == AW'(r));

        hazard_sb_entry #(
            .LAT_W(LAT_W)
        ) u_ent (
            .clk     (clk),
            .rst     (rst),
            .load    (hit_rd),
            .load_var(id_var),
            .load_lat(id_lat),
            .done    (hit_done),
            .busy    (busy_v[r]),
            .pend    (pend_v[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [AW-1:0] rs;

        assign rs = id_rs_addr[i*AW +: AW];
        assign haz_port[i] = id_valid & id_rs_read[i]
                           & (rs != '0) & busy_v[rs];
    end

    assign waw = id_valid & id_rd_we & rd_nz & pend_v[id_rd_addr];

    assign stall = (|haz_port) | waw;

    assign issue = id_valid & ~stall & ~flush & id_rd_we & rd_nz;

    assign busy_any = |busy_v;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
